// File: rtl/spi_target.sv
`default_nettype none
// ============================================================================
// Module   : spi_target
// Purpose  : SPI mode-0 target, fully oversampled in the CLK domain, with a
//            one-entry TX holding register and an RX strobe per received word.
// Revision : 1.0 - initial release
// ============================================================================
module spi_target #(
    parameter int                   SYNC_STAGES = 2,
    parameter int                   BIT_WIDTH   = 8,
    parameter logic [BIT_WIDTH-1:0] IDLE_FILL   = '1
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    input  logic                 CS_n,
    output logic                 MISO,
    output logic                 MISO_OE,
    output logic                 SELECTED,
    input  logic [BIT_WIDTH-1:0] TX_DATA,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic [BIT_WIDTH-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 TX_UNDERRUN
);

    localparam int                 c_CNT_W    = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(BIT_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sclk_sync;
    logic [SYNC_STAGES-1:0]   r_mosi_sync;
    logic [SYNC_STAGES-1:0]   r_cs_sync;
    logic                     r_sclk_prev;
    logic [c_CNT_W-1:0]       r_bit_cnt;
    logic [BIT_WIDTH-2:0]     r_rx_shift;
    logic [BIT_WIDTH-1:0]     r_tx_shift;
    logic [BIT_WIDTH-1:0]     r_hold;
    logic                     r_hold_full;
    logic [BIT_WIDTH-1:0]     r_rx_data;
    logic                     r_rx_valid;
    logic                     r_underrun;

    logic                     w_sclk_s;
    logic                     w_mosi_s;
    logic                     w_cs_active;
    logic                     w_sclk_rise;
    logic                     w_sclk_fall;
    logic                     w_load;
    logic                     w_tx_shift_en;
    logic                     w_rx_shift_en;
    logic                     w_rx_done;
    logic                     w_write;
    logic [BIT_WIDTH-1:0]     w_rx_word;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_active = ~r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    assign w_rx_word   = {r_rx_shift, w_mosi_s};
    assign w_write     = TX_VALID & ~r_hold_full;

    // CS_n synchronizer resets to the deselected level so reset release never fakes a frame start
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS_n};
            r_sclk_prev <= w_sclk_s;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_tx_shift_en = 1'b0;
        w_rx_shift_en = 1'b0;
        w_rx_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_active) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!w_cs_active) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (w_sclk_rise) begin
                        w_rx_shift_en = 1'b1;
                        w_rx_done     = (r_bit_cnt == c_LAST_BIT);
                    end
                    // a falling edge with the counter wrapped marks the word boundary
                    if (w_sclk_fall) begin
                        if (r_bit_cnt == '0) begin
                            w_load = 1'b1;
                        end else begin
                            w_tx_shift_en = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= w_rx_done;
            r_underrun <= w_load & ~r_hold_full;

            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_rx_shift_en) begin
                r_bit_cnt <= w_rx_done ? '0 : r_bit_cnt + 1'b1;
            end

            if (w_rx_shift_en) begin
                r_rx_shift <= w_rx_word[BIT_WIDTH-2:0];
            end
            if (w_rx_done) begin
                r_rx_data <= w_rx_word;
            end

            if (w_load) begin
                r_tx_shift <= r_hold_full ? r_hold : IDLE_FILL;
            end else if (w_tx_shift_en) begin
                r_tx_shift <= {r_tx_shift[BIT_WIDTH-2:0], 1'b0};
            end

            // a write coinciding with an empty-register load is kept for the following load
            if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
            if (w_write) begin
                r_hold      <= TX_DATA;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign SELECTED    = (r_state == ST_ACTIVE);
    assign MISO_OE     = SELECTED;
    assign MISO        = SELECTED ? r_tx_shift[BIT_WIDTH-1] : 1'b1;
    assign TX_READY    = ~r_hold_full;
    assign RX_DATA     = r_rx_data;
    assign RX_VALID    = r_rx_valid;
    assign TX_UNDERRUN = r_underrun;

endmodule
`default_nettype wire
